// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl
// Multi-cycle issue controller for the 16-bit combinational ALU. Accepts one
// instruction word per handshake, drives registered ALU operands/control,
// captures the ALU result and retires it into an internal 8x16 register file.
//
// Optional feature macro: ALU_SEQ_OVF_TRAP_EN
//   defined   : add/sub with overflow skips the rd write and pulses OVF_TRAP
//   undefined : wrapped result is written, OVF_TRAP stays 0
//
// Ports
//   CLK, RST_N        clock, synchronous active-low reset
//   INS_VALID/READY   instruction handshake, INS_WORD = {op,rd,rs1,rs2,shamt}
//   ALU_DA/DB/CTL/SHIFT  registered ALU drive
//   ALU_DC, ALU_OverFlow ALU result inputs, sampled at the end of EXE
//   DONE, RES         retire pulse and result (RES holds after DONE)
//   OVF_STICKY/CLR    sticky add/sub overflow flag and its clear
//   OVF_TRAP          overflow trap pulse, coincident with DONE
//   RD_ADDR/RD_DATA   combinational debug read of the register file
//
// state | meaning
// IDLE  | INS_READY=1, waiting for an instruction
// OPR   | load ALU operand/control registers from rf
// EXE   | ALU evaluates; capture result and overflow
// WB    | DONE/RES presented; rf write at end of cycle

module alu_seq_ctrl (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        INS_VALID,
    output logic        INS_READY,
    input  logic [15:0] INS_WORD,
    output logic [15:0] ALU_DA,
    output logic [15:0] ALU_DB,
    output logic [2:0]  ALU_CTL,
    output logic [3:0]  ALU_SHIFT,
    input  logic [15:0] ALU_DC,
    input  logic        ALU_OverFlow,
    output logic        DONE,
    output logic [15:0] RES,
    output logic        OVF_STICKY,
    input  logic        OVF_CLR,
    output logic        OVF_TRAP,
    input  logic [2:0]  RD_ADDR,
    output logic [15:0] RD_DATA
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_OPR  = 2'd1;
    localparam logic [1:0] S_EXE  = 2'd2;
    localparam logic [1:0] S_WB   = 2'd3;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_LOADI = 3'b111;

    logic [1:0]  state;
    logic [15:0] ins;
    // Entry 0 is never written, so it reads as zero without a special mux.
    logic [15:0] rf [8];

    logic [2:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [3:0]  shamt;
    logic [15:0] imm;
    logic        is_loadi;
    logic        is_addsub;
    logic        wb_en;

    assign op        = ins[15:13];
    assign rd        = ins[12:10];
    assign rs1       = ins[9:7];
    assign rs2       = ins[6:4];
    assign shamt     = ins[3:0];
    assign imm       = {{6{ins[9]}}, ins[9:0]};
    assign is_loadi  = (op == OP_LOADI);
    assign is_addsub = (op == OP_ADD) || (op == OP_SUB);

`ifdef ALU_SEQ_OVF_TRAP_EN
    // A trapped add/sub leaves rd untouched; OVF_TRAP is high during WB.
    assign wb_en = (rd != 3'd0) && !OVF_TRAP;
`else
    assign wb_en = (rd != 3'd0);
`endif

    assign RD_DATA = rf[RD_ADDR];

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state      <= S_IDLE;
            ins        <= 16'h0000;
            INS_READY  <= 1'b0;
            ALU_DA     <= 16'h0000;
            ALU_DB     <= 16'h0000;
            ALU_CTL    <= 3'b000;
            ALU_SHIFT  <= 4'h0;
            DONE       <= 1'b0;
            RES        <= 16'h0000;
            OVF_STICKY <= 1'b0;
            OVF_TRAP   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                rf[i] <= 16'h0000;
            end
        end else begin
            DONE     <= 1'b0;
            OVF_TRAP <= 1'b0;
            // Any set in EXE below is a later assignment and so wins.
            if (OVF_CLR) begin
                OVF_STICKY <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    INS_READY <= 1'b1;
                    if (INS_VALID && INS_READY) begin
                        ins       <= INS_WORD;
                        INS_READY <= 1'b0;
                        state     <= S_OPR;
                    end
                end
                S_OPR: begin
                    if (is_loadi) begin
                        ALU_DA    <= 16'h0000;
                        ALU_DB    <= 16'h0000;
                        ALU_CTL   <= 3'b000;
                        ALU_SHIFT <= 4'h0;
                    end else begin
                        ALU_DA    <= rf[rs1];
                        ALU_DB    <= rf[rs2];
                        ALU_CTL   <= op;
                        ALU_SHIFT <= shamt;
                    end
                    state <= S_EXE;
                end
                S_EXE: begin
                    DONE <= 1'b1;
                    RES  <= is_loadi ? imm : ALU_DC;
                    if (is_addsub && ALU_OverFlow) begin
                        OVF_STICKY <= 1'b1;
`ifdef ALU_SEQ_OVF_TRAP_EN
                        OVF_TRAP   <= 1'b1;
`endif
                    end
                    state <= S_WB;
                end
                S_WB: begin
                    if (wb_en) begin
                        rf[rd] <= RES;
                    end
                    INS_READY <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
module tb_alu_seq_ctrl;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        INS_VALID = 1'b0;
    logic        INS_READY;
    logic [15:0] INS_WORD = 16'h0000;
    logic [15:0] ALU_DA;
    logic [15:0] ALU_DB;
    logic [2:0]  ALU_CTL;
    logic [3:0]  ALU_SHIFT;
    logic [15:0] ALU_DC;
    logic        ALU_OverFlow;
    logic        DONE;
    logic [15:0] RES;
    logic        OVF_STICKY;
    logic        OVF_CLR = 1'b0;
    logic        OVF_TRAP;
    logic [2:0]  RD_ADDR = 3'd0;
    logic [15:0] RD_DATA;

    int checks = 0;
    int errors = 0;
    logic [16:0] sb_q [$];

`ifdef ALU_SEQ_OVF_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    alu_seq_ctrl dut (
        .CLK(CLK), .RST_N(RST_N), .INS_VALID(INS_VALID), .INS_READY(INS_READY),
        .INS_WORD(INS_WORD), .ALU_DA(ALU_DA), .ALU_DB(ALU_DB), .ALU_CTL(ALU_CTL),
        .ALU_SHIFT(ALU_SHIFT), .ALU_DC(ALU_DC), .ALU_OverFlow(ALU_OverFlow),
        .DONE(DONE), .RES(RES), .OVF_STICKY(OVF_STICKY), .OVF_CLR(OVF_CLR),
        .OVF_TRAP(OVF_TRAP), .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA)
    );

    always #5 CLK = ~CLK;

    // Combinational ALU environment. Non add/sub ops drive a junk overflow=1
    // so the controller must qualify the flag by opcode.
    logic [15:0] sum, dif;
    always_comb begin
        sum = ALU_DA + ALU_DB;
        dif = ALU_DA - ALU_DB;
        ALU_DC = 16'h0000;
        ALU_OverFlow = 1'b1;
        case (ALU_CTL)
            3'b000: begin
                ALU_DC = sum;
                ALU_OverFlow = (ALU_DA[15] == ALU_DB[15]) && (sum[15] != ALU_DA[15]);
            end
            3'b001: begin
                ALU_DC = dif;
                ALU_OverFlow = (ALU_DA[15] != ALU_DB[15]) && (dif[15] != ALU_DA[15]);
            end
            3'b010: ALU_DC = ALU_DA & ALU_DB;
            3'b011: ALU_DC = ALU_DA | ALU_DB;
            3'b100: ALU_DC = ALU_DA << ALU_SHIFT;
            3'b101: ALU_DC = ALU_DA >> ALU_SHIFT;
            3'b110: ALU_DC = $signed(ALU_DA) >>> ALU_SHIFT;
            default: ALU_DC = 16'h0000;
        endcase
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every DONE pulse must match the oldest expected retirement.
    always @(negedge CLK) begin
        if (DONE === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got DONE=1 RES=%h expected no retirement", RES);
            end else begin
                logic [16:0] e;
                e = sb_q.pop_front();
                chk("sb_res", RES, e[15:0]);
                chk("sb_trap", {15'd0, OVF_TRAP}, {15'd0, e[16]});
            end
        end
    end

    function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [2:0] rs2,
                                        input logic [3:0] sh);
        return {op, rd, rs1, rs2, sh};
    endfunction

    function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [9:0] imm);
        return {3'b111, rd, imm};
    endfunction

    task automatic rd_chk(input string nm, input logic [2:0] a, input logic [15:0] exp);
        RD_ADDR = a;
        #1;
        chk(nm, RD_DATA, exp);
    endtask

    task automatic issue(input logic [15:0] w, input logic [15:0] eres, input logic etrap,
                         input logic [2:0] ectl, input logic [3:0] esh, input logic clr_exe);
        int n;
        n = 0;
        @(negedge CLK);
        while (INS_READY !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got INS_READY=%b expected 1 within 20 cycles", INS_READY);
        end
        INS_VALID = 1'b1;
        INS_WORD = w;
        sb_q.push_back({etrap, eres});
        @(posedge CLK);
        #1;
        INS_VALID = 1'b0;
        INS_WORD = 16'hDEAD;
        @(negedge CLK);                                   // OPR
        chk("opr_ready", {15'd0, INS_READY}, 16'd0);
        chk("opr_done", {15'd0, DONE}, 16'd0);
        @(negedge CLK);                                   // EXE
        chk("exe_ctl", {13'd0, ALU_CTL}, {13'd0, ectl});
        chk("exe_shift", {12'd0, ALU_SHIFT}, {12'd0, esh});
        chk("exe_ready", {15'd0, INS_READY}, 16'd0);
        if (clr_exe) OVF_CLR = 1'b1;
        @(negedge CLK);                                   // WB
        OVF_CLR = 1'b0;
        chk("wb_done", {15'd0, DONE}, 16'd1);
        chk("wb_ready", {15'd0, INS_READY}, 16'd0);
        @(negedge CLK);                                   // back in IDLE
        chk("idle_done", {15'd0, DONE}, 16'd0);
        chk("idle_ready", {15'd0, INS_READY}, 16'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_ready", {15'd0, INS_READY}, 16'd0);
        chk("rst_da", ALU_DA, 16'd0);
        chk("rst_db", ALU_DB, 16'd0);
        chk("rst_ctl", {13'd0, ALU_CTL}, 16'd0);
        chk("rst_res", RES, 16'd0);
        chk("rst_done", {15'd0, DONE}, 16'd0);
        chk("rst_sticky", {15'd0, OVF_STICKY}, 16'd0);
        chk("rst_trap", {15'd0, OVF_TRAP}, 16'd0);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("ready_after_rst", {15'd0, INS_READY}, 16'd1);
        rd_chk("rst_r1", 3'd1, 16'h0000);

        issue(ldi(3'd1, 10'h1F5), 16'h01F5, 1'b0, 3'b000, 4'd0, 1'b0);
        rd_chk("r1_loadi", 3'd1, 16'h01F5);
        issue(ldi(3'd2, 10'h3FF), 16'hFFFF, 1'b0, 3'b000, 4'd0, 1'b0);
        rd_chk("r2_loadi", 3'd2, 16'hFFFF);

        issue(enc(3'b000, 3'd3, 3'd1, 3'd2, 4'd0), 16'h01F4, 1'b0, 3'b000, 4'd0, 1'b0);
        rd_chk("r3_add", 3'd3, 16'h01F4);
        issue(enc(3'b001, 3'd4, 3'd1, 3'd1, 4'd0), 16'h0000, 1'b0, 3'b001, 4'd0, 1'b0);
        rd_chk("r4_sub", 3'd4, 16'h0000);

        issue(ldi(3'd5, 10'h1FF), 16'h01FF, 1'b0, 3'b000, 4'd0, 1'b0);
        issue(enc(3'b100, 3'd6, 3'd5, 3'd0, 4'd6), 16'h7FC0, 1'b0, 3'b100, 4'd6, 1'b0);
        rd_chk("r6_sll", 3'd6, 16'h7FC0);
        chk("sticky_not_on_shift", {15'd0, OVF_STICKY}, 16'd0);
        issue(enc(3'b000, 3'd6, 3'd6, 3'd6, 4'd0), 16'hFF80, TRAP_EN, 3'b000, 4'd0, 1'b0);
        chk("sticky_after_ovf", {15'd0, OVF_STICKY}, 16'd1);
        rd_chk("r6_ovf", 3'd6, TRAP_EN ? 16'h7FC0 : 16'hFF80);

        issue(ldi(3'd1, 10'h200), 16'hFE00, 1'b0, 3'b000, 4'd0, 1'b0);
        issue(enc(3'b110, 3'd2, 3'd1, 3'd0, 4'd4), 16'hFFE0, 1'b0, 3'b110, 4'd4, 1'b0);
        issue(enc(3'b101, 3'd3, 3'd1, 3'd0, 4'd4), 16'h0FE0, 1'b0, 3'b101, 4'd4, 1'b0);
        issue(enc(3'b100, 3'd4, 3'd1, 3'd0, 4'd4), 16'hE000, 1'b0, 3'b100, 4'd4, 1'b0);
        rd_chk("r2_sra", 3'd2, 16'hFFE0);
        rd_chk("r3_srl", 3'd3, 16'h0FE0);
        rd_chk("r4_sll", 3'd4, 16'hE000);
        issue(enc(3'b010, 3'd5, 3'd1, 3'd4, 4'd0), 16'hE000, 1'b0, 3'b010, 4'd0, 1'b0);
        issue(enc(3'b011, 3'd7, 3'd2, 3'd3, 4'd0), 16'hFFE0, 1'b0, 3'b011, 4'd0, 1'b0);
        rd_chk("r7_or", 3'd7, 16'hFFE0);

        // Clear sticky alone, then overflow capture with a coincident clear.
        OVF_CLR = 1'b1;
        @(posedge CLK);
        #1;
        OVF_CLR = 1'b0;
        @(negedge CLK);
        chk("sticky_clr", {15'd0, OVF_STICKY}, 16'd0);
        issue(ldi(3'd7, 10'h1FF), 16'h01FF, 1'b0, 3'b000, 4'd0, 1'b0);
        issue(enc(3'b100, 3'd7, 3'd7, 3'd0, 4'd6), 16'h7FC0, 1'b0, 3'b100, 4'd6, 1'b0);
        issue(enc(3'b000, 3'd0, 3'd7, 3'd7, 4'd0), 16'hFF80, TRAP_EN, 3'b000, 4'd0, 1'b1);
        chk("sticky_set_wins", {15'd0, OVF_STICKY}, 16'd1);
        rd_chk("r0_discard", 3'd0, 16'h0000);
        OVF_CLR = 1'b1;
        @(posedge CLK);
        #1;
        OVF_CLR = 1'b0;
        @(negedge CLK);
        chk("sticky_clr2", {15'd0, OVF_STICKY}, 16'd0);

        // Reset during EXE of add r3,r1,r2: dropped with no retirement.
        INS_VALID = 1'b1;
        INS_WORD = enc(3'b000, 3'd3, 3'd1, 3'd2, 4'd0);
        @(posedge CLK);
        #1;
        INS_VALID = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b0;
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        @(negedge CLK);
        chk("mid_rst_done", {15'd0, DONE}, 16'd0);
        chk("mid_rst_ready", {15'd0, INS_READY}, 16'd0);
        chk("mid_rst_da", ALU_DA, 16'd0);
        chk("mid_rst_db", ALU_DB, 16'd0);
        chk("mid_rst_ctl", {13'd0, ALU_CTL}, 16'd0);
        chk("mid_rst_shift", {12'd0, ALU_SHIFT}, 16'd0);
        chk("mid_rst_res", RES, 16'd0);
        rd_chk("mid_rst_r3", 3'd3, 16'h0000);
        rd_chk("mid_rst_r1", 3'd1, 16'h0000);
        @(negedge CLK);
        chk("post_rst_done", {15'd0, DONE}, 16'd0);
        chk("post_rst_ready", {15'd0, INS_READY}, 16'd1);

        issue(ldi(3'd0, 10'h155), 16'h0155, 1'b0, 3'b000, 4'd0, 1'b0);
        rd_chk("r0_loadi", 3'd0, 16'h0000);
        issue(ldi(3'd1, 10'h2AA), 16'hFEAA, 1'b0, 3'b000, 4'd0, 1'b0);
        rd_chk("r1_after_rst", 3'd1, 16'hFEAA);

        repeat (2) @(negedge CLK);
        chk("sb_empty", sb_q.size()[15:0], 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
